// File: rtl/branch_resolve_unit.sv
// Branch resolution: ALU Z/N flag register, program counter and post-branch flush window.
// Optional BRANCH_FLAG_BYPASS_EN forwards alu_z/alu_n into a same-cycle BRZ/BRN condition.
module branch_resolve_unit #(
  parameter int unsigned    PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int unsigned    FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flag_we,
  input  logic            alu_z,
  input  logic            alu_n,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [1:0]      br_op,
  input  logic [PC_W-1:0] br_target,
  input  logic            stall,
  output logic [PC_W-1:0] pc,
  output logic            taken,
  output logic            flush,
  output logic            z_flag,
  output logic            n_flag
);

  localparam int unsigned CNT_W = 4;
  localparam logic [1:0] OP_J   = 2'b00;
  localparam logic [1:0] OP_BRZ = 2'b01;
  localparam logic [1:0] OP_BRN = 2'b10;

  typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              taken_q, taken_d;
  logic              flush_q, flush_d;
  logic              z_q, z_d;
  logic              n_q, n_d;
  logic              accept;
  logic              cond_z, cond_n, cond_met;

  assign br_ready = (state_q == S_RUN) & ~stall;
  assign accept   = br_valid & br_ready;

  // Condition flags: registered values, or the in-flight ALU flags when forwarding is built in
`ifdef BRANCH_FLAG_BYPASS_EN
  assign cond_z = flag_we ? alu_z : z_q;
  assign cond_n = flag_we ? alu_n : n_q;
`else
  assign cond_z = z_q;
  assign cond_n = n_q;
`endif

  always_comb begin
    cond_met = 1'b0;
    unique case (br_op)
      OP_J:    cond_met = 1'b1;
      OP_BRZ:  cond_met = cond_z;
      OP_BRN:  cond_met = cond_n;
      default: cond_met = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
    z_d     = z_q;
    n_d     = n_q;
    unique case (state_q)
      S_RUN: begin
        if (flag_we) begin
          z_d = alu_z;
          n_d = alu_n;
        end
        if (accept && cond_met) begin
          pc_d    = br_target;
          taken_d = 1'b1;
          state_d = S_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES);
        end else if (!stall) begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      S_FLUSH: begin
        // Flags from squashed instructions are dropped; the window counts even while stalled
        if (!stall) pc_d = pc_q + PC_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_RUN;
    endcase
    flush_d = (state_d == S_FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      flush_q <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      flush_q <= flush_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  assign pc     = pc_q;
  assign taken  = taken_q;
  assign flush  = flush_q;
  assign z_flag = z_q;
  assign n_flag = n_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: per-cycle reference model plus directed literal checks.
module tb_branch_resolve_unit;

  localparam int unsigned PC_W = 32;
  localparam int unsigned FC   = 2;

  logic            clk = 1'b0;
  logic            rst_n, rst_w_n;
  logic            flag_we, alu_z, alu_n, br_valid, stall;
  logic [1:0]      br_op;
  logic [PC_W-1:0] br_target;
  logic            br_ready, taken, flush, z_flag, n_flag;
  logic [PC_W-1:0] pc;
  logic            w_ready, w_taken, w_flush, w_z, w_n;
  logic [PC_W-1:0] w_pc;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.PC_W(PC_W), .RESET_PC('0), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .alu_z(alu_z), .alu_n(alu_n),
    .br_valid(br_valid), .br_ready(br_ready), .br_op(br_op), .br_target(br_target),
    .stall(stall), .pc(pc), .taken(taken), .flush(flush), .z_flag(z_flag), .n_flag(n_flag)
  );

  branch_resolve_unit #(.PC_W(PC_W), .RESET_PC(32'hFFFF_FFFE), .FLUSH_CYCLES(FC)) dut_w (
    .clk(clk), .rst_n(rst_w_n), .flag_we(1'b0), .alu_z(1'b0), .alu_n(1'b0),
    .br_valid(1'b0), .br_ready(w_ready), .br_op(2'b00), .br_target('0),
    .stall(1'b0), .pc(w_pc), .taken(w_taken), .flush(w_flush), .z_flag(w_z), .n_flag(w_n)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: flush_left = remaining flush cycles, 0 means running normally
  logic [31:0] m_pc;
  bit          m_z, m_n, m_taken;
  int          flush_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = '0; m_z = 0; m_n = 0; m_taken = 0; flush_left = 0;
    end else begin
      bit ready, acc, zc, nc, tk;
      ready = (flush_left == 0) && !stall;
      acc   = br_valid && ready;
      zc = m_z; nc = m_n;
`ifdef BRANCH_FLAG_BYPASS_EN
      if (flag_we) begin zc = alu_z; nc = alu_n; end
`endif
      tk = acc && ((br_op == 2'd0) || (br_op == 2'd1 && zc) || (br_op == 2'd2 && nc));
      if (flush_left == 0 && flag_we) begin m_z = alu_z; m_n = alu_n; end
      if (tk) begin
        m_pc = br_target; m_taken = 1; flush_left = FC;
      end else begin
        m_taken = 0;
        if (!stall) m_pc = m_pc + 1;
        if (flush_left > 0) flush_left--;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_pc", pc, m_pc);
      check("model_taken", 32'(taken), 32'(m_taken));
      check("model_flush", 32'(flush), 32'(flush_left > 0));
      check("model_z", 32'(z_flag), 32'(m_z));
      check("model_n", 32'(n_flag), 32'(m_n));
      check("model_ready", 32'(br_ready), 32'((flush_left == 0) && !stall));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    flag_we = 0; alu_z = 0; alu_n = 0; br_valid = 0; br_op = 2'b00; br_target = '0; stall = 0;
  endtask

  initial begin
    rst_n = 0; rst_w_n = 0;
    idle();
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_flush", 32'(flush), 32'h0);
    check("reset_ready", 32'(br_ready), 32'h1);
    @(negedge clk); rst_n = 1; rst_w_n = 1;
    #1 check("run_pc0", pc, 32'h0);
    check("wrap_pc0", w_pc, 32'hFFFF_FFFE);
    step(); check("run_pc1", pc, 32'h1);
    check("wrap_pc1", w_pc, 32'hFFFF_FFFF);
    step(); check("run_pc2", pc, 32'h2);
    check("wrap_pc2", w_pc, 32'h0);
    step(); check("run_pc3", pc, 32'h3);

    // Taken BRZ after a flag write
    flag_we = 1; alu_z = 1;
    step(); check("brz_zflag", 32'(z_flag), 32'h1); check("brz_pc4", pc, 32'h4);
    flag_we = 0; alu_z = 0; br_valid = 1; br_op = 2'b01; br_target = 32'h40;
    check("brz_ready", 32'(br_ready), 32'h1);
    step(); br_valid = 0;
    check("brz_pc", pc, 32'h40); check("brz_taken", 32'(taken), 32'h1);
    check("brz_flush1", 32'(flush), 32'h1); check("brz_ready_lo", 32'(br_ready), 32'h0);
    step(); check("brz_pc41", pc, 32'h41); check("brz_taken_off", 32'(taken), 32'h0);
    check("brz_flush2", 32'(flush), 32'h1);
    step(); check("brz_pc42", pc, 32'h42); check("brz_flush_end", 32'(flush), 32'h0);
    check("brz_ready_back", 32'(br_ready), 32'h1);

    // Jump to 3 so the flush window lands at pc = 5
    br_valid = 1; br_op = 2'b00; br_target = 32'h3;
    step(); br_valid = 0;
    step(); step(); check("j_pc5", pc, 32'h5);

    // Not-taken BRN with n_flag = 0
    br_valid = 1; br_op = 2'b10; br_target = 32'h80;
    step(); br_valid = 0;
    check("brn_pc6", pc, 32'h6); check("brn_taken", 32'(taken), 32'h0);
    check("brn_flush", 32'(flush), 32'h0);

    // Stall during flush with a branch and a flag write on offer
    br_valid = 1; br_op = 2'b00; br_target = 32'h100;
    step();
    stall = 1; br_target = 32'h200; flag_we = 1; alu_z = 0; alu_n = 1;
    check("st_ready", 32'(br_ready), 32'h0);
    step(); check("st_pc_hold", pc, 32'h100); check("st_flush", 32'(flush), 32'h1);
    check("st_z", 32'(z_flag), 32'h1); check("st_n", 32'(n_flag), 32'h0);
    idle(); stall = 1;
    step(); check("st_pc_hold2", pc, 32'h100); check("st_flush_end", 32'(flush), 32'h0);
    check("st_taken", 32'(taken), 32'h0);
    stall = 0;
    step(); check("st_pc_resume", pc, 32'h101);

    // Flag write coinciding with BRZ
    flag_we = 1; alu_z = 0; alu_n = 0;
    step(); check("bp_zclr", 32'(z_flag), 32'h0);
    flag_we = 1; alu_z = 1; br_valid = 1; br_op = 2'b01; br_target = 32'h10;
    step(); idle();
`ifdef BRANCH_FLAG_BYPASS_EN
    check("bp_pc", pc, 32'h10); check("bp_taken", 32'(taken), 32'h1);
`else
    check("bp_pc", pc, 32'h103); check("bp_taken", 32'(taken), 32'h0);
`endif
    check("bp_zset", 32'(z_flag), 32'h1);
    step(); step();

    // Reset asserted mid-flush
    br_valid = 1; br_op = 2'b00; br_target = 32'h55;
    step(); idle();
    check("mr_pc", pc, 32'h55); check("mr_flush", 32'(flush), 32'h1);
    #2 rst_n = 0;
    #1 check("mr_flush_clr", 32'(flush), 32'h0); check("mr_taken_clr", 32'(taken), 32'h0);
    check("mr_pc_reset", pc, 32'h0);
    @(negedge clk); @(negedge clk); rst_n = 1;
    #1 check("mr_ready", 32'(br_ready), 32'h1);
    step(); check("mr_pc1", pc, 32'h1); check("mr_flush_run", 32'(flush), 32'h0);
    step(); step();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
